// File: rtl/vec_sub_unpack_pkg.sv
// Shared constants, derived-size helpers and FSM encoding for the packed-row
// to byte-serial vector subtractor.
package vec_sub_unpack_pkg;

  localparam int P251_MOD = 251;

  localparam int M_L1    = 230;
  localparam int M_L3    = 352;
  localparam int M_L5    = 480;
  localparam int M_OTHER = 230;

  localparam int S_START_L1    = 126;
  localparam int S_START_L3    = 120;
  localparam int S_START_L5    = 150;
  localparam int S_START_OTHER = 3;

  // A packed row spans the full s vector, so its byte size tracks M.
  localparam int MAT_ROW_SIZE_BYTES_L1    = M_L1;
  localparam int MAT_ROW_SIZE_BYTES_L3    = M_L3;
  localparam int MAT_ROW_SIZE_BYTES_L5    = M_L5;
  localparam int MAT_ROW_SIZE_BYTES_OTHER = M_OTHER;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int n_bytes(int m, int s_start);
    return m - s_start;
  endfunction

  function automatic int n_words(int nbytes, int n_gf);
    return (nbytes + n_gf - 1) / n_gf;
  endfunction

  function automatic int last_bytes(int nbytes, int n_gf);
    return nbytes - (n_words(nbytes, n_gf) - 1) * n_gf;
  endfunction

  // Address widths never collapse to zero bits, even for one-entry spaces.
  function automatic int clog2_min1(int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/vec_sub_unpack_if.sv
// Start/done handshake, operand-word read port and byte-serial s write port.
interface vec_sub_unpack_if #(
  parameter int AW        = 4,
  parameter int SW        = 8,
  parameter int PROC_SIZE = 64
);
  logic                 start;
  logic                 done;
  logic                 word_rd;
  logic [AW-1:0]        word_addr;
  logic [PROC_SIZE-1:0] res;
  logic [PROC_SIZE-1:0] vec;
  logic [SW-1:0]        s_addr;
  logic [7:0]           s;
  logic                 s_wr_en;

  modport master (
    input  start, res, vec,
    output done, word_rd, word_addr, s_addr, s, s_wr_en
  );

  modport slave (
    output start, res, vec,
    input  done, word_rd, word_addr, s_addr, s, s_wr_en
  );
endinterface

// File: rtl/vec_sub_unpack_lane.sv
// One 8-bit lane subtractor: XOR for GF256, modular subtraction for P251.
module gf_p251_sub_lane
  import vec_sub_unpack_pkg::*;
#(
  parameter string FIELD = "GF256"
) (
  input  logic [7:0] i_r,
  input  logic [7:0] i_v,
  output logic [7:0] o_d
);

  if (FIELD == "P251") begin : g_p251
    // Operands are < 251, so one conditional add of the modulus suffices.
    assign o_d = (i_r >= i_v) ? (i_r - i_v) : (i_r - i_v + 8'(P251_MOD));
  end else begin : g_gf256
    assign o_d = i_r ^ i_v;
  end

endmodule

// File: rtl/vec_sub_unpack.sv
// Reads res/vec rows word by word, subtracts lane-wise and streams the
// difference bytes into s[S_START_ADDR .. M-1], MSB lane first.
//
// state | meaning
// IDLE  | waiting for start, counters at their start values
// FETCH | read word 0 of both operands
// LOAD  | operands valid, latch all lane differences
// EMIT  | one s byte per cycle, prefetching the next word two lanes early
// DONE  | one-cycle completion pulse
module vec_sub_unpack
  import vec_sub_unpack_pkg::*;
#(
  parameter string FIELD         = "GF256",
  parameter string PARAMETER_SET = "L1",
  parameter int    M             = (PARAMETER_SET == "L1") ? M_L1 :
                                   (PARAMETER_SET == "L3") ? M_L3 :
                                   (PARAMETER_SET == "L5") ? M_L5 : M_OTHER,
  parameter int    S_START_ADDR  = (PARAMETER_SET == "L1") ? S_START_L1 :
                                   (PARAMETER_SET == "L3") ? S_START_L3 :
                                   (PARAMETER_SET == "L5") ? S_START_L5 : S_START_OTHER,
  parameter int    N_GF          = 8,
  parameter int    PROC_SIZE     = N_GF * 8
) (
  input logic              i_clk,
  input logic              i_rst,
  vec_sub_unpack_if.master bus
);

  localparam int N_WORDS = n_words(n_bytes(M, S_START_ADDR), N_GF);
  localparam int AW      = clog2_min1(N_WORDS);
  localparam int SW      = clog2_min1(M);
  localparam int IW      = $clog2(N_GF);

  localparam logic [AW-1:0] LAST_WORD  = AW'(N_WORDS - 1);
  localparam logic [SW-1:0] LAST_ADDR  = SW'(M - 1);
  localparam logic [SW-1:0] FIRST_ADDR = SW'(S_START_ADDR);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_GF - 1);
  localparam logic [IW-1:0] IDX_PREF   = IW'(N_GF - 2);

  state_t               state_q, state_d;
  logic [AW-1:0]        word_addr_q, word_addr_d;
  logic [SW-1:0]        s_addr_q, s_addr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [PROC_SIZE-1:0] shift_q, shift_d;
  logic [PROC_SIZE-1:0] diff;
  logic [AW-1:0]        word_addr_o;
  logic                 word_rd, s_wr_en, done;

  for (genvar j = 0; j < N_GF; j++) begin : g_lane
    gf_p251_sub_lane #(.FIELD(FIELD)) u_lane (
      .i_r (bus.res[PROC_SIZE-1-8*j -: 8]),
      .i_v (bus.vec[PROC_SIZE-1-8*j -: 8]),
      .o_d (diff[PROC_SIZE-1-8*j -: 8])
    );
  end

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    s_addr_d    = s_addr_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    word_rd     = 1'b0;
    word_addr_o = word_addr_q;
    s_wr_en     = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_FETCH;
      ST_FETCH: begin
        word_rd = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = diff;
        idx_d   = '0;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        s_wr_en = 1'b1;
        // Read two lanes early so the fresh word lands on the last lane.
        if (idx_q == IDX_PREF && word_addr_q != LAST_WORD) begin
          word_rd     = 1'b1;
          word_addr_d = word_addr_q + AW'(1);
          word_addr_o = word_addr_d;
        end
        if (s_addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          s_addr_d = s_addr_q + SW'(1);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            shift_d = diff;
          end else begin
            idx_d   = idx_q + IW'(1);
            shift_d = shift_q << 8;
          end
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        word_addr_d = '0;
        s_addr_d    = FIRST_ADDR;
        idx_d       = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      word_addr_q <= '0;
      s_addr_q    <= FIRST_ADDR;
      idx_q       <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      s_addr_q    <= s_addr_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
    end
  end

  assign bus.word_rd   = word_rd;
  assign bus.word_addr = word_addr_o;
  assign bus.s_wr_en   = s_wr_en;
  assign bus.s_addr    = s_addr_q;
  assign bus.s         = shift_q[PROC_SIZE-1 -: 8];
  assign bus.done      = done;

endmodule

// File: tb/tb_vec_sub_unpack.sv
// Three instances (L1/GF256, other/GF256 with a partial last word, L1/P251)
// share start/reset and are checked every cycle against a byte-stream model.
module tb_vec_sub_unpack;

  localparam int NCFG = 3;
  localparam int S_A  [NCFG] = '{126, 3, 126};
  localparam int NB_A [NCFG] = '{104, 227, 104};
  localparam int NW_A [NCFG] = '{13, 29, 13};
  localparam bit P_A  [NCFG] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] res_mem [NCFG][32];
  logic [63:0] vec_mem [NCFG][32];
  logic        wr_w [NCFG];
  logic        rd_w [NCFG];
  logic        done_w [NCFG];
  logic [7:0]  s_w [NCFG];
  logic [15:0] sa_w [NCFG];
  logic [15:0] wa_w [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int AW = (g == 1) ? 5 : 4;
    vec_sub_unpack_if #(.AW(AW), .SW(8), .PROC_SIZE(64)) bus ();
    vec_sub_unpack #(
      .FIELD         ((g == 2) ? "P251" : "GF256"),
      .PARAMETER_SET ((g == 1) ? "other" : "L1")
    ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
    );
    assign bus.start = start;
    always @(posedge clk) begin
      if (bus.word_rd) begin
        bus.res <= res_mem[g][bus.word_addr];
        bus.vec <= vec_mem[g][bus.word_addr];
      end
    end
    assign wr_w[g]   = bus.s_wr_en;
    assign rd_w[g]   = bus.word_rd;
    assign done_w[g] = bus.done;
    assign s_w[g]    = bus.s;
    assign sa_w[g]   = 16'(bus.s_addr);
    assign wa_w[g]   = 16'(bus.word_addr);
  end

  int n_chk = 0;
  int n_fail = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  bit pat_run = 1'b0;
  bit act [NCFG];
  bit known [NCFG];
  int st [NCFG];
  int wrc [NCFG];
  int rdc [NCFG];

  task automatic chk(input string nm, input int g, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s cfg%0d cyc%0d: got %0d expected %0d", nm, g, cyc, a, e);
    end
  endtask

  // Byte b of the s stream: lane b%8 of word b/8, res minus vec in the field.
  function automatic int exp_byte(int g, int b);
    logic [63:0] rw, vw;
    int r, v;
    rw = res_mem[g][b / 8];
    vw = vec_mem[g][b / 8];
    r = int'(8'(rw >> (56 - 8 * (b % 8))));
    v = int'(8'(vw >> (56 - 8 * (b % 8))));
    if (P_A[g]) return (r - v + 251) % 251;
    return r ^ v;
  endfunction

  int rel, b, exp_ra;
  bit exp_wr, exp_rd;

  always @(negedge clk) begin
    if (tmo_cnt != tmo_seen) begin
      chk("wait_bound_expired", 0, tmo_cnt - tmo_seen, 0);
      tmo_seen = tmo_cnt;
    end
    for (int g = 0; g < NCFG; g++) begin
      rel = cyc - st[g] + 1;
      b   = rel - 3;
      if (known[g] && !act[g]) begin
        chk("idle_wr_en", g, int'(wr_w[g]), 0);
        chk("idle_word_rd", g, int'(rd_w[g]), 0);
        chk("idle_done", g, int'(done_w[g]), 0);
        chk("idle_s_addr", g, int'(sa_w[g]), S_A[g]);
        chk("idle_word_addr", g, int'(wa_w[g]), 0);
      end else if (act[g]) begin
        exp_wr = (b >= 0 && b < NB_A[g]);
        exp_rd = 1'b0;
        exp_ra = 0;
        if (rel == 1) begin
          exp_rd = 1'b1;
        end else if (exp_wr && (b % 8) == 6 && (b / 8 + 1) < NW_A[g]) begin
          exp_rd = 1'b1;
          exp_ra = b / 8 + 1;
        end
        chk("wr_en", g, int'(wr_w[g]), int'(exp_wr));
        if (exp_wr && wr_w[g]) begin
          chk("s_addr", g, int'(sa_w[g]), S_A[g] + b);
          chk("s_data", g, int'(s_w[g]), exp_byte(g, b));
          if (g == 0 && pat_run) chk("pattern_a5_xor_k", g, int'(s_w[g]), int'(8'hA5 ^ 8'(b / 8)));
          if (g == 2 && b < 3) chk("p251_literal", g, int'(s_w[g]), (b == 0) ? 244 : (b == 1) ? 250 : 0);
          if (g == 1 && b == NB_A[g] - 1) chk("last_write_addr", g, int'(sa_w[g]), 229);
        end
        chk("word_rd", g, int'(rd_w[g]), int'(exp_rd));
        if (exp_rd && rd_w[g]) chk("word_addr", g, int'(wa_w[g]), exp_ra);
        chk("done", g, int'(done_w[g]), int'(rel == 3 + NB_A[g]));
        if (wr_w[g]) wrc[g]++;
        if (rd_w[g]) rdc[g]++;
        if (rel == 3 + NB_A[g]) begin
          chk("run_write_count", g, wrc[g], (g == 1) ? 227 : 104);
          chk("run_read_count", g, rdc[g], (g == 1) ? 29 : 13);
          if (g == 0) chk("done_cycle", g, rel, 107);
        end
      end
      if (rst) begin
        act[g]   = 1'b0;
        known[g] = 1'b1;
      end else if (act[g] && rel == 3 + NB_A[g]) begin
        act[g] = 1'b0;
      end else if (!act[g] && known[g] && start) begin
        act[g] = 1'b1;
        st[g]  = cyc + 1;
        wrc[g] = 0;
        rdc[g] = 0;
      end
    end
  end

  task automatic fill(input bit pat);
    logic [63:0] rw, vw;
    pat_run = pat;
    for (int g = 0; g < NCFG; g++) begin
      for (int w = 0; w < 32; w++) begin
        rw = '0;
        vw = '0;
        for (int j = 0; j < 8; j++) begin
          if (pat && g == 0) begin
            rw[63-8*j -: 8] = 8'hA5;
            vw[63-8*j -: 8] = 8'(w);
          end else begin
            rw[63-8*j -: 8] = 8'($urandom_range(P_A[g] ? 250 : 255, 0));
            vw[63-8*j -: 8] = 8'($urandom_range(P_A[g] ? 250 : 255, 0));
          end
        end
        if (g == 2 && w == 0) begin
          rw[63:40] = {8'd3, 8'd250, 8'd7};
          vw[63:40] = {8'd10, 8'd0, 8'd7};
        end
        res_mem[g][w] = rw;
        vec_mem[g][w] = vw;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((act[0] || act[1] || act[2]) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= bound) tmo_cnt++;
  endtask

  task automatic wait_done0(input int bound);
    int n = 0;
    while (!done_w[0] && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= bound) tmo_cnt++;
  endtask

  initial begin
    fill(1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    fill(1'b1);
    pulse_start();
    wait_idle(600);

    fill(1'b0);
    pulse_start();
    repeat (20) @(posedge clk);
    #1 pulse_start();
    wait_done0(300);
    pulse_start();
    wait_idle(600);

    fill(1'b0);
    pulse_start();
    wait_done0(300);
    @(posedge clk); #1;
    pulse_start();
    wait_idle(600);

    fill(1'b0);
    pulse_start();
    repeat (51) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 pulse_start();
    wait_idle(600);

    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    for (int k = 0; k < 3; k++) begin
      fill(1'b0);
      pulse_start();
      wait_idle(600);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
